// File: rtl/ddc_cfg_pkg.sv
// Shared definitions for the DDC filter-chain configuration handshake.
// Used by the stream master here and by the slave-side controller.
package ddc_cfg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        STREAM,
        WAIT_DONE,
        ERR
    } cfgState_t;

    // Word counts of each filter stage image, in chain order.
    localparam int CIC_CFG_NUM   = 3;
    localparam int CICC_CFG_NUM  = 259;
    localparam int MHBF_CFG_NUM  = 176;
    localparam int DFIR_CFG_NUM  = 516;
    localparam int DDC_CFG_TOTAL = CIC_CFG_NUM + CICC_CFG_NUM + MHBF_CFG_NUM + DFIR_CFG_NUM;

endpackage

// File: rtl/ddc_config_stream_master_ram.sv
// Simple dual-port coefficient image buffer.
// One host write port and one registered read port that holds its value while rdEn is low.
module config_word_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  wrEn,
    input  logic [ADDR_WIDTH-1:0] wrAddr,
    input  logic [DATA_WIDTH-1:0] wrData,
    input  logic                  rdEn,
    input  logic [ADDR_WIDTH-1:0] rdAddr,
    output logic [DATA_WIDTH-1:0] rdData
);

    logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

    always_ff @(posedge clock) begin
        if (wrEn) begin
            mem[wrAddr] <= wrData;
        end
    end

    // The read register doubles as the stream output register, so it alone carries a reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rdData <= '0;
        end else if (rdEn) begin
            rdData <= mem[rdAddr];
        end
    end

endmodule

// File: rtl/ddc_config_stream_master.sv
// Initiator side of the DDC filter-chain config handshake: request, wait for ACK,
// stream the preloaded coefficient image one word per cycle, then wait for the slave's done.
module ddc_config_stream_master
    import ddc_cfg_pkg::*;
#(
    parameter int CONFIG_WIDTH = 32,
    parameter int BUF_DEPTH    = 1024,
    parameter int ADDR_WIDTH   = 10,
    parameter int ACK_TIMEOUT  = 4096,
    parameter int DONE_TIMEOUT = 65536
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic                           Host_Wr_En,
    input  logic [ADDR_WIDTH-1:0]          Host_Wr_Addr,
    input  logic [CONFIG_WIDTH-1:0]        Host_Wr_Data,
    input  logic [ADDR_WIDTH:0]            Cfg_Len,
    input  logic                           Start,
    output logic                           Busy,
    output logic                           Done,
    output logic                           Error,
    output logic                           isConfig,
    output logic signed [CONFIG_WIDTH-1:0] Data_Config_Out,
    input  logic                           isConfigACK,
    input  logic                           isConfigDone
);

    localparam int CNT_W   = ADDR_WIDTH + 1;
    localparam int TMR_MAX = (ACK_TIMEOUT > DONE_TIMEOUT) ? ACK_TIMEOUT : DONE_TIMEOUT;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0] ACK_LAST  = TMR_W'(ACK_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] DONE_LAST = TMR_W'(DONE_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] LEN_MAX   = CNT_W'(BUF_DEPTH);

    cfgState_t state;
    cfgState_t stateNext;

    logic [CNT_W-1:0]      cfgLen;
    logic [CNT_W-1:0]      wordIdx;
    logic [CNT_W-1:0]      nextIdx;
    logic [TMR_W-1:0]      timer;
    logic                  lastWord;
    logic                  lenOk;
    logic                  badStart;
    logic                  doneNext;
    logic                  busyInt;
    logic                  doneQ;
    logic                  errorQ;
    logic                  rdEn;
    logic [ADDR_WIDTH-1:0] rdAddr;
    logic                  wrEn;
    logic [CONFIG_WIDTH-1:0] rdData;

    assign nextIdx  = wordIdx + CNT_W'(1);
    assign lastWord = (nextIdx == cfgLen);
    assign lenOk    = (Cfg_Len != '0) && (Cfg_Len <= LEN_MAX);

    // isConfig and Busy decode straight from the state register so an async reset drops them at once.
    assign busyInt  = (state == REQ) || (state == STREAM) || (state == WAIT_DONE);
    assign Busy     = busyInt;
    assign isConfig = busyInt;
    assign Done     = doneQ;
    assign Error    = errorQ;

    assign wrEn            = Host_Wr_En && !busyInt;
    assign Data_Config_Out = rdData;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Word k is the RAM output in stream cycle k: REQ keeps reading address 0 so word 0 is
    // ready the cycle after ACK, then the read address stays one word ahead.
    always_comb begin
        stateNext = state;
        badStart  = 1'b0;
        doneNext  = 1'b0;
        rdEn      = 1'b0;
        rdAddr    = '0;
        case (state)
            IDLE: begin
                if (Start) begin
                    if (lenOk) begin
                        stateNext = REQ;
                    end else begin
                        badStart = 1'b1;
                    end
                end
            end
            REQ: begin
                rdEn = 1'b1;
                if (isConfigACK) begin
                    stateNext = STREAM;
                end else if (timer == ACK_LAST) begin
                    stateNext = ERR;
                end
            end
            STREAM: begin
                rdEn   = !lastWord;
                rdAddr = nextIdx[ADDR_WIDTH-1:0];
                if (isConfigDone) begin
                    stateNext = ERR;
                end else if (lastWord) begin
                    stateNext = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (isConfigDone) begin
                    stateNext = IDLE;
                    doneNext  = 1'b1;
                end else if (timer == DONE_LAST) begin
                    stateNext = ERR;
                end
            end
            ERR: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // The timeout counter restarts on every state change and only advances while waiting on the slave.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cfgLen  <= '0;
            wordIdx <= '0;
            timer   <= '0;
            doneQ   <= 1'b0;
            errorQ  <= 1'b0;
        end else begin
            doneQ  <= doneNext;
            errorQ <= badStart || (stateNext == ERR);
            if (state == IDLE && Start && lenOk) begin
                cfgLen <= Cfg_Len;
            end
            if (state == REQ) begin
                wordIdx <= '0;
            end else if (state == STREAM && !lastWord) begin
                wordIdx <= nextIdx;
            end
            if (state != stateNext) begin
                timer <= '0;
            end else if (state == REQ || state == WAIT_DONE) begin
                timer <= timer + TMR_W'(1);
            end
        end
    end

    config_word_ram #(
        .DATA_WIDTH(CONFIG_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clock (CLK),
        .reset (RST),
        .wrEn  (wrEn),
        .wrAddr(Host_Wr_Addr),
        .wrData(Host_Wr_Data),
        .rdEn  (rdEn),
        .rdAddr(rdAddr),
        .rdData(rdData)
    );

endmodule
